// File: rtl/mips_instr_encoder_loader.sv
// Packs decoded MIPS fields into 32-bit words and streams them into instruction memory from byte address 0.
// Latency: mem_we rises one cycle after a field handshake, so back-to-back writes run at one word per cycle.
// Backpressure: in_ready drops while a pending write is stalled (mem_ready low), after HALT and in DONE/ERR.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              restart loading at address 0 (any state)
//   in_valid/in_ready  field handshake; in_op, in_rs, in_rt, in_rd, in_imm are the decoded fields
//   mem_we/mem_ready   write handshake; mem_addr (byte address), mem_wdata (encoded word)
//   done, err          level status; err_code 01 = illegal opcode, 10 = memory overflow
//   instr_count        words accepted by memory since reset/start
module mips_instr_encoder_loader #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [31:0]       instr_count
);

    localparam logic [5:0] OP_HALT     = 6'd17;
    localparam logic [5:0] OP_LWD      = 6'd12;
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_OVF     = 2'b10;

    typedef enum logic [1:0] {
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    // Instruction word layout; the low half carries {rd, shamt, funct} for
    // R-type and the immediate for I-type.
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] low;
    } instr_t;

    state_t            state, state_nxt;
    logic              mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [31:0]       mem_wdata_nxt;
    logic              done_nxt;
    logic              err_nxt;
    logic [1:0]        err_code_nxt;
    logic [31:0]       instr_count_nxt;
    // HALT has been accepted and its write is still outstanding.
    logic              halt_pend, halt_pend_nxt;

    logic              fld_hs;
    logic              wr_hs;
    logic              op_illegal;
    logic              mem_full;
    logic [32:0]       words_committed;

    // R-type ops are the even opcodes 0..16 except 12; I-type are the odd
    // opcodes 1..15 plus 12. HALT carries only its opcode.
    function automatic logic [31:0] encode(input logic [5:0]  op,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [4:0]  rd,
                                           input logic [15:0] imm);
        instr_t w;
        w    = '0;
        w.op = op;
        if (op != OP_HALT) begin
            w.rs = rs;
            w.rt = rt;
            if (op[0] || op == OP_LWD) begin
                w.low = imm;
            end else begin
                w.low = {rd, 11'b0};
            end
        end
        return w;
    endfunction

    always_comb begin
        wr_hs    = mem_we && mem_ready;
        in_ready = (state == S_LOAD) && !start && !halt_pend && (!mem_we || mem_ready);
        fld_hs   = in_valid && in_ready;

        op_illegal = in_op > OP_HALT;
        // Words already in memory plus the one waiting on the bus; when this
        // reaches DEPTH there is no slot left for the incoming word.
        words_committed = {1'b0, instr_count} + 33'(mem_we);
        mem_full        = words_committed == 33'(DEPTH);

        state_nxt       = state;
        mem_we_nxt      = mem_we;
        mem_addr_nxt    = mem_addr;
        mem_wdata_nxt   = mem_wdata;
        done_nxt        = done;
        err_nxt         = err;
        err_code_nxt    = err_code;
        instr_count_nxt = instr_count;
        halt_pend_nxt   = halt_pend;

        if (wr_hs) begin
            mem_we_nxt      = 1'b0;
            instr_count_nxt = instr_count + 32'd1;
            mem_addr_nxt    = mem_addr + ADDR_W'(4);
            if (halt_pend) begin
                halt_pend_nxt = 1'b0;
                state_nxt     = S_DONE;
                done_nxt      = 1'b1;
            end
        end

        // in_ready guarantees any pending write completes this same cycle,
        // so an abort here never strands a word on the bus.
        if (fld_hs) begin
            if (op_illegal) begin
                state_nxt    = S_ERR;
                err_nxt      = 1'b1;
                err_code_nxt = ERR_ILLEGAL;
            end else if (mem_full) begin
                state_nxt    = S_ERR;
                err_nxt      = 1'b1;
                err_code_nxt = ERR_OVF;
            end else begin
                mem_we_nxt    = 1'b1;
                mem_wdata_nxt = encode(in_op, in_rs, in_rt, in_rd, in_imm);
                halt_pend_nxt = (in_op == OP_HALT);
            end
        end

        if (start) begin
            state_nxt       = S_LOAD;
            mem_we_nxt      = 1'b0;
            mem_addr_nxt    = '0;
            instr_count_nxt = '0;
            done_nxt        = 1'b0;
            err_nxt         = 1'b0;
            err_code_nxt    = ERR_NONE;
            halt_pend_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_LOAD;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            instr_count <= '0;
            halt_pend   <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_we      <= mem_we_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_wdata   <= mem_wdata_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
            err_code    <= err_code_nxt;
            instr_count <= instr_count_nxt;
            halt_pend   <= halt_pend_nxt;
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder_loader.sv
// Directed bench for mips_instr_encoder_loader: encoding table, stall, HALT, illegal opcode, overflow, reset.
// Inputs change on the falling edge; outputs are read on the falling edge (registers) or 1 ns later (in_ready).
// A second instance with DEPTH=4 shares the inputs and is checked only for the overflow case.
`timescale 1ns/1ps
module tb_mips_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, mem_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;

    logic        in_ready, mem_we, done, err;
    logic [31:0] mem_addr, mem_wdata, instr_count;
    logic [1:0]  err_code;

    logic        in_ready4, mem_we4, done4, err4;
    logic [31:0] mem_addr4, mem_wdata4, instr_count4;
    logic [1:0]  err_code4;

    always #5 clk = ~clk;

    mips_instr_encoder_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .err(err), .err_code(err_code), .instr_count(instr_count)
    );

    mips_instr_encoder_loader #(.DEPTH(4), .ADDR_W(32)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .mem_we(mem_we4), .mem_ready(mem_ready), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .done(done4), .err(err4), .err_code(err_code4), .instr_count(instr_count4)
    );

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] exp_word;
    } vec_t;

    vec_t        vecs[6];
    vec_t        st_vecs[5];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the handshake.
    task automatic send(input bit use4, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
        bit acc;
        acc      = 1'b0;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            #1;
            acc = use4 ? in_ready4 : in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: op %h never accepted, expected acceptance within 40 cycles", op);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Write monitor: the handshake completes at the next rising edge when these hold.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && !start && mem_we && mem_ready) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{6'd0,  5'd1,  5'd2,  5'd3,  16'hFFFF, 32'h00221800};
        vecs[1] = '{6'd1,  5'd1,  5'd2,  5'd0,  16'hFFFC, 32'h0422FFFC};
        vecs[2] = '{6'd12, 5'd0,  5'd5,  5'd9,  16'h0008, 32'h30050008};
        vecs[3] = '{6'd14, 5'd31, 5'd31, 5'd31, 16'hFFFF, 32'h3BFFF800};
        vecs[4] = '{6'd15, 5'd0,  5'd0,  5'd31, 16'h1234, 32'h3C001234};
        vecs[5] = '{6'd16, 5'd2,  5'd3,  5'd4,  16'hFFFF, 32'h40432000};

        st_vecs[0] = '{6'd2,  5'd1,  5'd1, 5'd1, 16'h0000, 32'h08210800};
        st_vecs[1] = '{6'd3,  5'd2,  5'd3, 5'd0, 16'h00AA, 32'h0C4300AA};
        st_vecs[2] = '{6'd4,  5'd4,  5'd5, 5'd6, 16'hFFFF, 32'h10853000};
        st_vecs[3] = '{6'd5,  5'd0,  5'd0, 5'd7, 16'h8000, 32'h14008000};
        st_vecs[4] = '{6'd13, 5'd31, 5'd0, 5'd0, 16'h0001, 32'h37E00001};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_we",   32'(mem_we),   32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_addr",     mem_addr,      32'd0);
        check("rst_wdata",    mem_wdata,     32'd0);
        check("rst_count",    instr_count,   32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Encoding table, back-to-back at one word per cycle
        for (int i = 0; i < 6; i++) begin
            send(1'b0, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm);
            check($sformatf("vec%0d_we", i),    32'(mem_we), 32'd1);
            check($sformatf("vec%0d_wdata", i), mem_wdata,   vecs[i].exp_word);
            check($sformatf("vec%0d_addr", i),  mem_addr,    32'(i * 4));
            check($sformatf("vec%0d_count", i), instr_count, 32'(i));
        end
        @(negedge clk);
        check("tbl_idle_we", 32'(mem_we), 32'd0);
        check("tbl_count",   instr_count, 32'd6);
        check("tbl_addr",    mem_addr,    32'd24);

        // Stall mid-stream
        pulse_start();
        #1;
        check("st_start_in_ready", 32'(in_ready), 32'd1);
        check("st_start_count",    instr_count,   32'd0);
        check("st_start_addr",     mem_addr,      32'd0);
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send(1'b0, st_vecs[k].op, st_vecs[k].rs, st_vecs[k].rt, st_vecs[k].rd, st_vecs[k].imm);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                mem_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    #1;
                    check($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
                    check($sformatf("stall%0d_we", k),       32'(mem_we),   32'd1);
                    check($sformatf("stall%0d_addr", k),     mem_addr,      32'd4);
                    check($sformatf("stall%0d_wdata", k),    mem_wdata,     st_vecs[1].exp_word);
                    @(negedge clk);
                end
                mem_ready = 1'b1;
            end
        join
        repeat (2) @(negedge clk);
        check("stall_nwrites", 32'(wr_addr_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < wr_addr_q.size(); k++) begin
            check($sformatf("stall_wr%0d_addr", k), wr_addr_q[k], 32'(k * 4));
            check($sformatf("stall_wr%0d_data", k), wr_data_q[k], st_vecs[k].exp_word);
        end
        check("stall_count", instr_count, 32'd5);

        // HALT after two words; fields on the HALT must not leak
        pulse_start();
        send(1'b0, 6'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF);
        send(1'b0, 6'd1, 5'd1, 5'd2, 5'd0, 16'hFFFC);
        send(1'b0, 6'd17, 5'd5, 5'd6, 5'd7, 16'hFFFF);
        check("halt_we",    32'(mem_we), 32'd1);
        check("halt_wdata", mem_wdata,   32'h44000000);
        check("halt_addr",  mem_addr,    32'd8);
        #1;
        check("halt_pend_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("halt_done",  32'(done),   32'd1);
        check("halt_we_lo", 32'(mem_we), 32'd0);
        check("halt_count", instr_count, 32'd3);
        check("halt_err",   32'(err),    32'd0);
        in_valid = 1'b1;
        in_op    = 6'd0;
        #1;
        check("done_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("done_no_write", 32'(mem_we), 32'd0);
        check("done_count",    instr_count, 32'd3);
        check("done_level",    32'(done),   32'd1);

        // Illegal opcode right behind a legal word
        pulse_start();
        send(1'b0, 6'd0, 5'd1, 5'd2, 5'd3, 16'h0000);
        send(1'b0, 6'h3F, 5'd1, 5'd2, 5'd3, 16'h0000);
        check("ill_err",      32'(err),      32'd1);
        check("ill_err_code", 32'(err_code), 32'd1);
        check("ill_no_we",    32'(mem_we),   32'd0);
        check("ill_count",    instr_count,   32'd1);
        check("ill_done",     32'(done),     32'd0);
        #1;
        check("ill_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("ill_err_hold", 32'(err), 32'd1);
        pulse_start();
        #1;
        check("rs_in_ready", 32'(in_ready), 32'd1);
        check("rs_addr",     mem_addr,      32'd0);
        check("rs_count",    instr_count,   32'd0);
        check("rs_err",      32'(err),      32'd0);
        check("rs_err_code", 32'(err_code), 32'd0);
        @(negedge clk);

        // Overflow on the DEPTH=4 instance
        pulse_start();
        for (int k = 0; k < 5; k++) send(1'b1, 6'd0, 5'd1, 5'd2, 5'd3, 16'h0000);
        check("ovf_err",      32'(err4),      32'd1);
        check("ovf_err_code", 32'(err_code4), 32'd2);
        check("ovf_no_we",    32'(mem_we4),   32'd0);
        check("ovf_count",    instr_count4,   32'd4);
        check("ovf_addr",     mem_addr4,      32'd16);
        #1;
        check("ovf_in_ready", 32'(in_ready4), 32'd0);
        @(negedge clk);

        // Reset while a write is stalled
        pulse_start();
        mem_ready = 1'b0;
        send(1'b0, 6'd0, 5'd1, 5'd2, 5'd3, 16'h0000);
        check("rstall_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstall_mem_we",   32'(mem_we),    32'd0);
        check("rstall_addr",     mem_addr,       32'd0);
        check("rstall_wdata",    mem_wdata,      32'd0);
        check("rstall_count",    instr_count,    32'd0);
        check("rstall_done",     32'(done),      32'd0);
        check("rstall_err",      32'(err),       32'd0);
        check("rstall_err_code", 32'(err_code),  32'd0);
        check("rstall4_err",     32'(err4),      32'd0);
        check("rstall4_done",    32'(done4),     32'd0);
        check("rstall4_wdata",   mem_wdata4,     32'd0);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
